serial_subtractor: RTL
======================

SERIAL_SUBTRACTOR -- requirements
Module: serial_subtractor

Interface
REQ-001 Parameter: WIDTH, default 8, operand/result width in bits; legal range 1..64.
REQ-002 Port: clk  input  1  sole clock; all state updates on rising edge.
REQ-003 Port: rst  input  1  reset, synchronous, active-high.
REQ-004 Port: start  input  1  request; sampled only in IDLE.
REQ-005 Port: mode  input  1  0 = subtract (A-B-Bin), 1 = add (A+B+Bin).
REQ-006 Port: A  input  WIDTH  minuend/addend.
REQ-007 Port: B  input  WIDTH  subtrahend/addend.
REQ-008 Port: Bin  input  1  borrow-in (subtract) or carry-in (add).
REQ-009 Port: busy  output  1  high whenever state != IDLE.
REQ-010 Port: done  output  1  single-cycle pulse, result valid.
REQ-011 Port: Diff  output  WIDTH  result (difference or sum).
REQ-012 Port: Bout  output  1  final borrow-out (subtract) or carry-out (add).
REQ-013 Port: ovf  output  1  two's-complement signed overflow.
REQ-014 Port: zero  output  1  high when Diff == 0.

Function
REQ-015 The block SHALL implement FSM states IDLE, RUN, DONE, computing one bit per cycle, LSB first, through a single full-subtractor/full-adder cell and a 1-bit borrow/carry register.
REQ-016 In IDLE with start=1 at edge k: latch A, B, Bin, mode; clear bit index; state -> RUN; start=0 keeps IDLE.
REQ-017 RUN SHALL process bit i at edge k+1+i, i = 0..WIDTH-1; A, B, Bin, mode changes after edge k SHALL NOT affect the result.
REQ-018 Subtract bit: d = a^b^c; c' = (~a&b) | (~(a^b)&c); add bit: s = a^b^c; c' = (a&b) | (c&(a^b)); c initialised from latched Bin.
REQ-019 After edge k+WIDTH: state -> DONE, done=1, Diff/Bout/ovf/zero updated; after edge k+WIDTH+1: state -> IDLE, done=0. Latency start-to-done = WIDTH cycles; throughput one operation per WIDTH+2 cycles.
REQ-020 Bout SHALL equal the final c' of bit WIDTH-1.
REQ-021 ovf (subtract) = (A[msb] != B[msb]) && (Diff[msb] != A[msb]); ovf (add) = (A[msb] == B[msb]) && (Diff[msb] != A[msb]); latched operands used.
REQ-022 Diff, Bout, ovf, zero SHALL be registered, change only on the DONE-entry edge, and hold until the next DONE entry.
REQ-023 start while busy=1 (RUN or DONE) SHALL be ignored, with no queuing.
REQ-024 WIDTH=1 SHALL reproduce the 1-bit full subtractor truth table (mode=0) with latency 1.
REQ-025 Results SHALL be exact modulo 2^WIDTH for all operands, including wrap-around (0 - 1 -> all ones, Bout=1).

Reset
REQ-026 rst=1 at any edge SHALL force state IDLE, busy=0, done=0, Diff=0, Bout=0, ovf=0, zero=1, borrow register=0, bit index=0.
REQ-027 rst SHALL take priority over start at the same edge; reset mid-RUN SHALL abort the operation, with no done pulse and no result update.
REQ-028 A start at the first edge after rst deasserts SHALL be accepted normally.

Verification (WIDTH=8 unless stated)
REQ-029 mode=0, A=0x00, B=0x01, Bin=0 -> done at start+8, Diff=0xFF, Bout=1, ovf=0, zero=0.
REQ-030 mode=0, A=0x80, B=0x01, Bin=0 -> Diff=0x7F, Bout=0, ovf=1; then A=0x05, B=0x05, Bin=1 -> Diff=0xFF, Bout=1, ovf=0.
REQ-031 mode=1, A=0x7F, B=0x01, Bin=0 -> Diff=0x80, Bout=0, ovf=1; A=0xFF, B=0x01, Bin=0 -> Diff=0x00, Bout=1, zero=1.
REQ-032 start pulsed again at start+3 with different operands -> ignored, first result delivered unchanged, busy high throughout.
REQ-033 rst asserted at start+4 -> busy=0 next cycle, no done pulse, outputs at reset values; a new start then completes correctly.
REQ-034 WIDTH=1, all 8 {A, B, Bin} combinations, mode=0 -> Diff/Bout match the full subtractor truth table (e.g. 0,1,1 -> Diff=0, Bout=1).

Source files
------------

// File: rtl/serial_subtractor.sv
// rtl/serial_subtractor.sv - bit-serial LSB-first subtractor/adder with one full cell and a 1-bit borrow/carry register
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             mode,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] Diff,
    output logic             Bout,
    output logic             ovf,
    output logic             zero
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_sh_q, a_sh_d;
    logic [WIDTH-1:0] b_sh_q, b_sh_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic [CNT_W-1:0] idx_q, idx_d;
    logic             a_msb_q, a_msb_d;
    logic             b_msb_q, b_msb_d;
    logic             mode_q, mode_d;
    logic             c_q, c_d;
    logic             bout_q, bout_d;
    logic             ovf_q, ovf_d;
    logic             zero_q, zero_d;

    logic bit_a, bit_b, bit_s, bit_c, last_bit;

    // Single full-subtractor / full-adder cell fed by the operand shift registers
    always_comb begin
        bit_a    = a_sh_q[0];
        bit_b    = b_sh_q[0];
        bit_s    = bit_a ^ bit_b ^ c_q;
        bit_c    = mode_q ? ((bit_a & bit_b) | (c_q & (bit_a ^ bit_b)))
                          : ((~bit_a & bit_b) | (~(bit_a ^ bit_b) & c_q));
        last_bit = (idx_q == LAST_IDX);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = RUN;
            RUN:     if (last_bit) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy = (state_q != IDLE);
        done = (state_q == DONE);
        Diff = diff_q;
        Bout = bout_q;
        ovf  = ovf_q;
        zero = zero_q;
    end

    always_comb begin
        a_sh_d  = a_sh_q;
        b_sh_d  = b_sh_q;
        acc_d   = acc_q;
        diff_d  = diff_q;
        idx_d   = idx_q;
        a_msb_d = a_msb_q;
        b_msb_d = b_msb_q;
        mode_d  = mode_q;
        c_d     = c_q;
        bout_d  = bout_q;
        ovf_d   = ovf_q;
        zero_d  = zero_q;
        if (state_q == IDLE && start) begin
            a_sh_d  = A;
            b_sh_d  = B;
            a_msb_d = A[WIDTH-1];
            b_msb_d = B[WIDTH-1];
            mode_d  = mode;
            c_d     = Bin;
            idx_d   = '0;
            acc_d   = '0;
        end else if (state_q == RUN) begin
            a_sh_d = a_sh_q >> 1;
            b_sh_d = b_sh_q >> 1;
            c_d    = bit_c;
            idx_d  = idx_q + CNT_W'(1);
            // Result bits enter at the MSB so the word is aligned after WIDTH shifts
            acc_d  = (acc_q >> 1) | (WIDTH'(bit_s) << (WIDTH - 1));
            if (last_bit) begin
                idx_d  = '0;
                diff_d = acc_d;
                bout_d = bit_c;
                zero_d = (acc_d == '0);
                ovf_d  = mode_q ? ((a_msb_q == b_msb_q) && (acc_d[WIDTH-1] != a_msb_q))
                                : ((a_msb_q != b_msb_q) && (acc_d[WIDTH-1] != a_msb_q));
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_sh_q  <= '0;
            b_sh_q  <= '0;
            acc_q   <= '0;
            diff_q  <= '0;
            idx_q   <= '0;
            a_msb_q <= 1'b0;
            b_msb_q <= 1'b0;
            mode_q  <= 1'b0;
            c_q     <= 1'b0;
            bout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            zero_q  <= 1'b1;
        end else begin
            a_sh_q  <= a_sh_d;
            b_sh_q  <= b_sh_d;
            acc_q   <= acc_d;
            diff_q  <= diff_d;
            idx_q   <= idx_d;
            a_msb_q <= a_msb_d;
            b_msb_q <= b_msb_d;
            mode_q  <= mode_d;
            c_q     <= c_d;
            bout_q  <= bout_d;
            ovf_q   <= ovf_d;
            zero_q  <= zero_d;
        end
    end

endmodule
